// File: rtl/en_exmem_ctrl_if.sv
// Bus bundle between the ElectronNest core external-memory ports, the
// single-port SRAM and en_exmem_ctrl. The token structs live here so the
// controller and its environment share one definition.
//
// Handshake rules, in one place:
//   Load token: O_Ld_FTk.v offers a word. The word is taken on a clock edge
//     where .v is high and I_Ld_BTk.n is low. While .v & .n the offered word
//     holds its value.
//   Load request: I_Ld_Req/I_Ld_Addr are held by the core until O_Ld_Ack,
//     which is combinational and marks the cycle the SRAM read is issued.
//   Store: a store is offered with I_St_Req & I_St_FTk.v and is taken in
//     the same cycle unless O_St_BTk.n is high, in which case the core keeps
//     it offered and retries.
//   SRAM: O_Mem_CE/O_Mem_WE/O_Mem_Addr/O_Mem_WData are sampled at the clock
//     edge; read data appears on I_Mem_RData in the following cycle.
interface en_exmem_ctrl_if #(
  parameter int WIDTH_EXADDR = 16,
  parameter int WIDTH_DATA   = 32
);

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic c;
  } BTk_t;

  // boot control
  logic                    I_Boot;
  logic                    O_Boot_Done;

  // core load port
  logic                    I_Ld_Req;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr;
  logic                    O_Ld_Ack;
  FTk_t                    O_Ld_FTk;
  BTk_t                    I_Ld_BTk;

  // core store port
  logic                    I_St_Req;
  logic [WIDTH_EXADDR-1:0] I_St_Addr;
  FTk_t                    I_St_FTk;
  BTk_t                    O_St_BTk;

  // SRAM port
  logic                    O_Mem_CE;
  logic                    O_Mem_WE;
  logic [WIDTH_EXADDR-1:0] O_Mem_Addr;
  logic [WIDTH_DATA-1:0]   O_Mem_WData;
  logic [WIDTH_DATA-1:0]   I_Mem_RData;

  // controller view
  modport slave (
    input  I_Boot,
    output O_Boot_Done,
    input  I_Ld_Req,
    input  I_Ld_Addr,
    output O_Ld_Ack,
    output O_Ld_FTk,
    input  I_Ld_BTk,
    input  I_St_Req,
    input  I_St_Addr,
    input  I_St_FTk,
    output O_St_BTk,
    output O_Mem_CE,
    output O_Mem_WE,
    output O_Mem_Addr,
    output O_Mem_WData,
    input  I_Mem_RData
  );

  // core + SRAM view
  modport master (
    output I_Boot,
    input  O_Boot_Done,
    output I_Ld_Req,
    output I_Ld_Addr,
    input  O_Ld_Ack,
    input  O_Ld_FTk,
    output I_Ld_BTk,
    output I_St_Req,
    output I_St_Addr,
    output I_St_FTk,
    input  O_St_BTk,
    input  O_Mem_CE,
    input  O_Mem_WE,
    input  O_Mem_Addr,
    input  O_Mem_WData,
    output I_Mem_RData
  );

endinterface

// File: rtl/en_exmem_ctrl.sv
// ElectronNest external-memory controller.
// Boots the core (dummy acquire/valid words, then program words read from
// SRAM), then shares the single SRAM port between core loads and stores with
// round-robin fairness. Load data is shown to the core in the cycle after the
// read, straight from the SRAM output; a word the core stalls is parked in a
// one-entry skid register and shown from there until taken.
// Assumes BOOT_DUMMY >= 1 and BOOT_WORDS >= 1.
module en_exmem_ctrl #(
  parameter int WIDTH_EXADDR = 16,
  parameter int WIDTH_DATA   = 32,
  parameter int BOOT_DUMMY   = 3,
  parameter int BOOT_WORDS   = 5,
  parameter int BOOT_BASE    = 0,
  parameter int EXTEND_IDX   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  en_exmem_ctrl_if.slave        bus,
  output logic [1:0]            o_dbg_state
);

  localparam int DCW = $clog2(BOOT_DUMMY + 1);
  localparam int WCW = $clog2(BOOT_WORDS + 1);

  localparam logic [DCW-1:0] DUMMY_LAST = DCW'(BOOT_DUMMY - 1);
  localparam logic [WCW-1:0] WORDS_LAST = WCW'(BOOT_WORDS - 1);
  localparam logic [WCW-1:0] WORDS_N    = WCW'(BOOT_WORDS);
  localparam logic [DCW-1:0] DCNT_ONE   = DCW'(1);
  localparam logic [WCW-1:0] WCNT_ONE   = WCW'(1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_BOOT_DUMMY = 2'd1,
    S_BOOT_LOAD  = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                  state_q,   state_d;
  logic [DCW-1:0]          dcnt_q,    dcnt_d;     // dummy words accepted
  logic [WCW-1:0]          fcnt_q,    fcnt_d;     // boot reads issued
  logic [WCW-1:0]          acnt_q,    acnt_d;     // boot words accepted
  logic                    rd_pend_q, rd_pend_d;  // read data on I_Mem_RData now
  logic [WIDTH_EXADDR-1:0] rd_i_q,    rd_i_d;     // .i for that read
  logic                    skid_v_q,  skid_v_d;
  logic [WIDTH_DATA-1:0]   skid_d_q,  skid_d_d;
  logic [WIDTH_EXADDR-1:0] skid_i_q,  skid_i_d;
  logic                    rr_ld_q,   rr_ld_d;    // 1: last grant was a load
  logic                    done_q,    done_d;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic                    word_v;
  logic                    word_a;
  logic [WIDTH_DATA-1:0]   word_d;
  logic [WIDTH_EXADDR-1:0] word_i;
  logic                    stall;
  logic                    accept;
  logic                    boot_rd;
  logic                    ld_elig;
  logic                    st_elig;
  logic                    ld_grant;
  logic                    st_grant;

  // Token fields the controller never looks at.
  logic unused_fields;
  assign unused_fields = ^{bus.I_Ld_BTk.t, bus.I_Ld_BTk.c,
                           bus.I_St_FTk.a, bus.I_St_FTk.r,
                           bus.I_St_FTk.c, bus.I_St_FTk.i};

  // Select the word offered to the core: dummy during BOOT_DUMMY, otherwise
  // the skid entry first, then fresh SRAM data.
  always_comb begin
    word_v = 1'b0;
    word_a = 1'b0;
    word_d = '0;
    word_i = '0;
    case (state_q)
      S_BOOT_DUMMY: begin
        word_v = 1'b1;
        word_a = (dcnt_q == '0);
      end
      S_BOOT_LOAD, S_RUN: begin
        if (skid_v_q) begin
          word_v = 1'b1;
          word_d = skid_d_q;
          word_i = skid_i_q;
        end else if (rd_pend_q) begin
          word_v = 1'b1;
          word_d = bus.I_Mem_RData;
          word_i = rd_i_q;
        end
      end
      default: ;
    endcase
  end

  assign stall  = word_v &  bus.I_Ld_BTk.n;
  assign accept = word_v & ~bus.I_Ld_BTk.n;

  // Decide which SRAM access happens this cycle: boot fetch or RUN arbitration.
  always_comb begin
    boot_rd  = 1'b0;
    ld_elig  = 1'b0;
    st_elig  = bus.I_St_Req & bus.I_St_FTk.v;
    ld_grant = 1'b0;
    st_grant = 1'b0;
    case (state_q)
      // The first program read goes out with the last dummy word so that
      // program words follow the dummies without a bubble.
      S_BOOT_DUMMY: boot_rd = accept && (dcnt_q == DUMMY_LAST);
      S_BOOT_LOAD:  boot_rd = (fcnt_q != WORDS_N) && !stall && !skid_v_q;
      S_RUN: begin
        ld_elig = bus.I_Ld_Req & ~stall & ~skid_v_q;
        if (ld_elig && st_elig) begin
          ld_grant = ~rr_ld_q;
          st_grant =  rr_ld_q;
        end else begin
          ld_grant = ld_elig;
          st_grant = st_elig;
        end
      end
      default: ;
    endcase
  end

  // Drive the bus outputs.
  always_comb begin
    bus.O_Boot_Done   = done_q;
    bus.O_Ld_Ack      = ld_grant;

    bus.O_Ld_FTk      = '0;
    bus.O_Ld_FTk.v    = word_v;
    bus.O_Ld_FTk.a    = word_a;
    bus.O_Ld_FTk.i    = word_i;
    bus.O_Ld_FTk.d    = word_d;

    // Gated by reset so the core sees a quiet back token while held in reset.
    bus.O_St_BTk      = '0;
    bus.O_St_BTk.n    = reset & st_elig & ~st_grant;

    bus.O_Mem_CE      = boot_rd | ld_grant | st_grant;
    bus.O_Mem_WE      = st_grant;
    bus.O_Mem_WData   = st_grant ? bus.I_St_FTk.d : '0;
    if (st_grant) begin
      bus.O_Mem_Addr = bus.I_St_Addr;
    end else if (ld_grant) begin
      bus.O_Mem_Addr = bus.I_Ld_Addr;
    end else if (boot_rd) begin
      bus.O_Mem_Addr = WIDTH_EXADDR'(BOOT_BASE) + WIDTH_EXADDR'(fcnt_q);
    end else begin
      bus.O_Mem_Addr = '0;
    end
  end

  assign o_dbg_state = state_q;

  // Next-state: FSM, boot counters, read tracking, skid and RR pointer.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    fcnt_d    = fcnt_q;
    acnt_d    = acnt_q;
    done_d    = done_q;
    rr_ld_d   = rr_ld_q;
    skid_v_d  = skid_v_q;
    skid_d_d  = skid_d_q;
    skid_i_d  = skid_i_q;
    rd_pend_d = boot_rd | ld_grant;
    rd_i_d    = '0;
    if (ld_grant && (EXTEND_IDX != 0)) begin
      rd_i_d = bus.I_Ld_Addr;
    end

    // Fresh read data that the core refuses is parked; the skid empties
    // when its word is taken.
    if (skid_v_q) begin
      if (accept) begin
        skid_v_d = 1'b0;
      end
    end else if (rd_pend_q && stall) begin
      skid_v_d = 1'b1;
      skid_d_d = bus.I_Mem_RData;
      skid_i_d = rd_i_q;
    end

    if (boot_rd) begin
      fcnt_d = fcnt_q + WCNT_ONE;
    end

    if (ld_grant) begin
      rr_ld_d = 1'b1;
    end else if (st_grant) begin
      rr_ld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.I_Boot) begin
          state_d = S_BOOT_DUMMY;
          dcnt_d  = '0;
          fcnt_d  = '0;
          acnt_d  = '0;
        end
      end
      S_BOOT_DUMMY: begin
        if (accept) begin
          dcnt_d = dcnt_q + DCNT_ONE;
          if (dcnt_q == DUMMY_LAST) begin
            state_d = S_BOOT_LOAD;
          end
        end
      end
      S_BOOT_LOAD: begin
        if (accept) begin
          acnt_d = acnt_q + WCNT_ONE;
          if (acnt_q == WORDS_LAST) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: ;  // S_RUN holds until reset
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dcnt_q    <= '0;
      fcnt_q    <= '0;
      acnt_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_i_q    <= '0;
      skid_v_q  <= 1'b0;
      skid_d_q  <= '0;
      skid_i_q  <= '0;
      rr_ld_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      fcnt_q    <= fcnt_d;
      acnt_q    <= acnt_d;
      rd_pend_q <= rd_pend_d;
      rd_i_q    <= rd_i_d;
      skid_v_q  <= skid_v_d;
      skid_d_q  <= skid_d_d;
      skid_i_q  <= skid_i_d;
      rr_ld_q   <= rr_ld_d;
      done_q    <= done_d;
    end
  end

endmodule
